// File: rtl/nonce_bank.sv
// Multi-lane nonce generator: loads a seed byte-serially, fans it out as base+k and steps each lane by LANES.
// Optional feature macro NONCE_BANK_LOAD_TIMEOUT_EN abandons a partial seed after TIMEOUT_CYCLES idle cycles.
module nonce_bank #(
    parameter int WIDTH          = 256,
    parameter int LANES          = 4,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_valid_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     advance_i,
    input  logic [LANES-1:0]         lane_ready_i,
    output logic [LANES*WIDTH-1:0]   nonce_o,
    output logic                     nonce_valid_o,
    output logic                     loading_o,
    output logic                     wrap_o
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [WIDTH-1:0] STEP      = WIDTH'(LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEED = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   lane_q [LANES];
    logic [WIDTH-1:0]   lane_d [LANES];
    logic               wrap_q, wrap_d;
    logic [WIDTH:0]     sum_s;

`ifdef NONCE_BANK_LOAD_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               timeout_s;

    assign timeout_s = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
`endif

    // Shift one received byte into the shadow seed in the configured byte order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh, input logic [7:0] b);
        if (MSB_FIRST != 0) begin
            shift_in = {sh[WIDTH-9:0], b};
        end else begin
            shift_in = {b, sh[WIDTH-1:8]};
        end
    endfunction

    // Next-state logic for the load FSM, lane registers and sticky wrap flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        lane_d   = lane_q;
        wrap_d   = wrap_q;
        sum_s    = '0;
`ifdef NONCE_BANK_LOAD_TIMEOUT_EN
        idle_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    shadow_d = shift_in(shadow_q, rx_data_i);
                    if (NBYTES == 1) begin
                        cnt_d   = '0;
                        state_d = ST_SEED;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (rx_valid_i) begin
                    shadow_d = shift_in(shadow_q, rx_data_i);
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = ST_SEED;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
`ifdef NONCE_BANK_LOAD_TIMEOUT_EN
                    if (timeout_s) begin
                        cnt_d    = '0;
                        shadow_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        idle_d   = idle_q + IDLE_W'(1);
                    end
`else
                    state_d = ST_LOAD;
`endif
                end
            end
            ST_SEED: begin
                if (rx_valid_i) begin
                    shadow_d = shift_in(shadow_q, rx_data_i);
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_LOAD;
                end else begin
                    wrap_d = 1'b0;
                    for (int k = 0; k < LANES; k++) begin
                        sum_s     = {1'b0, shadow_q} + {1'b0, WIDTH'(k)};
                        lane_d[k] = sum_s[WIDTH-1:0];
                        wrap_d    = wrap_d | sum_s[WIDTH];
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rx_valid_i) begin
                    // A new seed byte wins over any step requested this cycle.
                    shadow_d = shift_in(shadow_q, rx_data_i);
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_LOAD;
                end else if (advance_i) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (lane_ready_i[k]) begin
                            sum_s     = {1'b0, lane_q[k]} + {1'b0, STEP};
                            lane_d[k] = sum_s[WIDTH-1:0];
                            wrap_d    = wrap_d | sum_s[WIDTH];
                        end else begin
                            lane_d[k] = lane_q[k];
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, seed and lane registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            lane_q   <= '{default: '0};
            wrap_q   <= 1'b0;
`ifdef NONCE_BANK_LOAD_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            lane_q   <= lane_d;
            wrap_q   <= wrap_d;
`ifdef NONCE_BANK_LOAD_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign nonce_o[g*WIDTH +: WIDTH] = lane_q[g];
    end

    assign nonce_valid_o = (state_q == ST_RUN);
    assign loading_o     = (state_q == ST_LOAD);
    assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_nonce_bank.sv
// Directed bench: a 256-bit/4-lane LSB-first bank and a 16-bit/2-lane MSB-first bank.
module tb_nonce_bank;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          rx_valid_a = 1'b0;
    logic [7:0]    rx_data_a  = 8'h00;
    logic          adv_a      = 1'b0;
    logic [3:0]    rdy_a      = 4'h0;
    logic [1023:0] nonce_a;
    logic          valid_a, loading_a, wrap_a;

    logic          rx_valid_b = 1'b0;
    logic [7:0]    rx_data_b  = 8'h00;
    logic          adv_b      = 1'b0;
    logic [1:0]    rdy_b      = 2'b00;
    logic [31:0]   nonce_b;
    logic          valid_b, loading_b, wrap_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    nonce_bank #(.WIDTH(256), .LANES(4), .MSB_FIRST(0), .TIMEOUT_CYCLES(50)) dut_a (
        .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid_a), .rx_data_i(rx_data_a),
        .advance_i(adv_a), .lane_ready_i(rdy_a), .nonce_o(nonce_a),
        .nonce_valid_o(valid_a), .loading_o(loading_a), .wrap_o(wrap_a)
    );

    nonce_bank #(.WIDTH(16), .LANES(2), .MSB_FIRST(1), .TIMEOUT_CYCLES(50)) dut_b (
        .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid_b), .rx_data_i(rx_data_b),
        .advance_i(adv_b), .lane_ready_i(rdy_b), .nonce_o(nonce_b),
        .nonce_valid_o(valid_b), .loading_o(loading_b), .wrap_o(wrap_b)
    );

    typedef struct {
        logic        rx;
        logic [7:0]  data;
        logic        adv;
        logic [1:0]  rdy;
        logic [15:0] l0;
        logic [15:0] l1;
        logic        v;
        logic        ld;
        logic        w;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_valid_a = 1'b1;
        rx_data_a  = b;
        tick();
        rx_valid_a = 1'b0;
    endtask

    function automatic logic [255:0] lane_a(input int k);
        return nonce_a[k*256 +: 256];
    endfunction

    logic [255:0] exp_seed;

    initial begin
        //              rx    data   adv   rdy    lane0     lane1    v     ld    w
        vecs[0]  = '{1'b1, 8'hFF, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'hFE, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 2'b00, 16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 2'b10, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 2'b00, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 2'b11, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 2'b01, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 2'b11, 16'h0002, 16'h0003, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'h00, 1'b1, 2'b11, 16'h0002, 16'h0003, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 8'h05, 1'b0, 2'b00, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 2'b00, 16'h0005, 16'h0006, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 2'b11, 16'h0007, 16'h0008, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h12, 1'b0, 2'b00, 16'h0007, 16'h0008, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'h34, 1'b0, 2'b00, 16'h0007, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'h56, 1'b0, 2'b00, 16'h0007, 16'h0008, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 8'h78, 1'b0, 2'b00, 16'h0007, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 2'b00, 16'h5678, 16'h5679, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 8'hFF, 1'b0, 2'b00, 16'h5678, 16'h5679, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 8'hFF, 1'b0, 2'b00, 16'h5678, 16'h5679, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) chk($sformatf("rst_a_lane%0d", k), lane_a(k), 256'd0);
        chk("rst_a_flags", {253'd0, valid_a, loading_a, wrap_a}, 256'd0);
        chk("rst_b_nonce", {224'd0, nonce_b}, 256'd0);
        chk("rst_b_flags", {253'd0, valid_b, loading_b, wrap_b}, 256'd0);

        // Narrow MSB-first bank: vector table, one cycle per record.
        for (int i = 0; i < 20; i++) begin
            rx_valid_b = vecs[i].rx;
            rx_data_b  = vecs[i].data;
            adv_b      = vecs[i].adv;
            rdy_b      = vecs[i].rdy;
            tick();
            chk($sformatf("b_v%0d_lane0", i), {240'd0, nonce_b[15:0]}, {240'd0, vecs[i].l0});
            chk($sformatf("b_v%0d_lane1", i), {240'd0, nonce_b[31:16]}, {240'd0, vecs[i].l1});
            chk($sformatf("b_v%0d_valid", i), {255'd0, valid_b}, {255'd0, vecs[i].v});
            chk($sformatf("b_v%0d_loading", i), {255'd0, loading_b}, {255'd0, vecs[i].ld});
            chk($sformatf("b_v%0d_wrap", i), {255'd0, wrap_b}, {255'd0, vecs[i].w});
        end
        rx_valid_b = 1'b0;
        adv_b      = 1'b0;
        rdy_b      = 2'b00;

        // Wide bank: seed 1 sent LSB first.
        send_a(8'h01);
        for (int i = 0; i < 30; i++) send_a(8'h00);
        chk("a_load_before_last", {255'd0, loading_a}, 256'd1);
        send_a(8'h00);
        chk("a_seed_flags", {253'd0, valid_a, loading_a, wrap_a}, 256'd0);
        tick();
        for (int k = 0; k < 4; k++) chk($sformatf("a_seed_lane%0d", k), lane_a(k), 256'(k + 1));
        chk("a_run_flags", {253'd0, valid_a, loading_a, wrap_a}, 256'b100);

        adv_a = 1'b1;
        rdy_a = 4'b0101;
        repeat (3) tick();
        adv_a = 1'b0;
        rdy_a = 4'b0000;
        chk("a_step_lane0", lane_a(0), 256'd13);
        chk("a_step_lane1", lane_a(1), 256'd2);
        chk("a_step_lane2", lane_a(2), 256'd15);
        chk("a_step_lane3", lane_a(3), 256'd4);

        // Seed byte and step request in the same cycle: the byte wins.
        adv_a = 1'b1;
        rdy_a = 4'b1111;
        send_a(8'h10);
        adv_a = 1'b0;
        rdy_a = 4'b0000;
        chk("a_prio_lane0", lane_a(0), 256'd13);
        chk("a_prio_lane2", lane_a(2), 256'd15);
        chk("a_prio_flags", {254'd0, valid_a, loading_a}, 256'b01);
        for (int i = 0; i < 30; i++) send_a(8'h00);
        chk("a_prio_cnt_loading", {255'd0, loading_a}, 256'd1);
        send_a(8'h00);
        chk("a_prio_cnt_seed", {255'd0, loading_a}, 256'd0);
        tick();
        for (int k = 0; k < 4; k++) chk($sformatf("a_reseed_lane%0d", k), lane_a(k), 256'(16 + k));

        // Partial new seed mid-run, then reset everything.
        for (int i = 0; i < 10; i++) send_a(8'hA5);
        chk("a_midrun_flags", {254'd0, valid_a, loading_a}, 256'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) chk($sformatf("a_rst2_lane%0d", k), lane_a(k), 256'd0);
        chk("a_rst2_flags", {253'd0, valid_a, loading_a, wrap_a}, 256'd0);
        chk("b_rst2_nonce", {224'd0, nonce_b}, 256'd0);
        chk("b_rst2_wrap", {255'd0, wrap_b}, 256'd0);

        // Partial load followed by 50 idle cycles.
        for (int i = 0; i < 5; i++) send_a(8'h11);
        repeat (49) tick();
        chk("a_idle49_loading", {255'd0, loading_a}, 256'd1);
        tick();
`ifdef NONCE_BANK_LOAD_TIMEOUT_EN
        chk("a_timeout_loading", {255'd0, loading_a}, 256'd0);
`else
        chk("a_notimeout_loading", {255'd0, loading_a}, 256'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        exp_seed = '0;
        for (int i = 0; i < 32; i++) begin
            exp_seed[8*i +: 8] = 8'(i + 1);
            send_a(8'(i + 1));
        end
        tick();
        chk("a_full_lane0", lane_a(0), exp_seed);
        chk("a_full_lane3", lane_a(3), exp_seed + 256'd3);
        chk("a_full_flags", {253'd0, valid_a, loading_a, wrap_a}, 256'b100);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
